// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the controller top and its bench.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  function automatic logic reg_match(input logic use_r, input logic [4:0] rs, input logic [4:0] rd);
    return use_r && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard controller.
// The pipeline side is the master; the controller is the slave.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             dmem_busy;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             ctrl_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, imem_ready, dmem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall,
           ctrl_err, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, imem_ready, dmem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall,
           ctrl_err, stall_cycles, flush_events
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, fetch gaps and data-memory waits with a watchdog.
module hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DMEM_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  import hazard_ctrl_pkg::*;

  state_e          state_q;
  state_e          state_d;
  logic [TO_W-1:0] wait_cnt_q;
  logic [TO_W-1:0] wait_cnt_d;
  logic            ctrl_err_q;
  logic            ctrl_err_d;

  logic load_use;
  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_stall;

  assign load_use = hif.ex_memread && (hif.ex_rd != REG_ZERO) &&
                    (reg_match(hif.id_use_rs1, hif.id_rs1, hif.ex_rd) ||
                     reg_match(hif.id_use_rs2, hif.id_rs2, hif.ex_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      ctrl_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    ctrl_err_d   = ctrl_err_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;

    if (state_q == ERR) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      ctrl_err_d   = 1'b1;
    end else if (hif.dmem_busy) begin
      // A busy memory freezes everything, including a taken branch held in EX.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      if (wait_cnt_q == TO_W'(DMEM_TIMEOUT)) begin
        state_d    = ERR;
        ctrl_err_d = 1'b1;
      end else begin
        state_d    = DWAIT;
        wait_cnt_d = wait_cnt_q + TO_W'(1);
      end
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (hif.ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!hif.imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (hif.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_id_flush),
    .count (hif.flush_events)
  );

  assign hif.pc_stall     = pc_stall;
  assign hif.if_id_stall  = if_id_stall;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.id_ex_flush  = id_ex_flush;
  assign hif.ex_mem_stall = ex_mem_stall;
  assign hif.ctrl_err     = ctrl_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters and a short watchdog.
// Strobe vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall}.
module tb_hazard_ctrl;

  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 3;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(
    .CNT_W        (CNT_W),
    .DMEM_TIMEOUT (4),
    .TO_W         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  logic [4:0] strobes;
  assign strobes = {hif.pc_stall, hif.if_id_stall, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic br, input logic imr, input logic busy);
    hif.ex_memread      = mr;
    hif.ex_rd           = rd;
    hif.id_rs1          = rs1;
    hif.id_rs2          = rs2;
    hif.id_use_rs1      = u1;
    hif.id_use_rs2      = u2;
    hif.ex_branch_taken = br;
    hif.imem_ready      = imr;
    hif.dmem_busy       = busy;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;

    // Reset: hazardous inputs must not leak onto the strobes.
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_strobes", 32'(strobes), 32'h00);
    step();
    checkOutput("rst_strobes2", 32'(strobes), 32'h00);
    checkOutput("rst_stall_cnt", 32'(hif.stall_cycles), 32'd0);
    checkOutput("rst_flush_cnt", 32'(hif.flush_events), 32'd0);
    checkOutput("rst_err", 32'(hif.ctrl_err), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(RUN));
    rst = 1'b0;
    idle();
    checkOutput("idle_strobes", 32'(strobes), 32'h00);

    // Load-use on rs1: one-cycle bubble
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lu_rs1", 32'(strobes), 32'b11010);
    step();
    idle();
    checkOutput("lu_bubble", 32'(strobes), 32'h00);
    checkOutput("lu_stall_cnt", 32'(hif.stall_cycles), 32'd1);
    checkOutput("lu_flush_cnt", 32'(hif.flush_events), 32'd0);

    // Load to x0 and unused operand are not hazards; rs2 match is
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("lu_x0", 32'(strobes), 32'h00);
    applyStimulus(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lu_rs2_unused", 32'(strobes), 32'h00);
    applyStimulus(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("no_load", 32'(strobes), 32'h00);
    applyStimulus(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("lu_rs2", 32'(strobes), 32'b11010);

    // Branch overrides load-use
    doReset();
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("br_over_lu", 32'(strobes), 32'b00110);
    step();
    idle();
    checkOutput("br_flush_cnt", 32'(hif.flush_events), 32'd1);
    checkOutput("br_stall_cnt", 32'(hif.stall_cycles), 32'd0);

    // Fetch gap, then busy together with branch (stall wins)
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("imem_gap", 32'(strobes), 32'b10100);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("busy_over_br", 32'(strobes), 32'b11001);

    // Memory wait of three cycles
    doReset();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("dwait_strobes%0d", i), 32'(strobes), 32'b11001);
      step();
      checkOutput($sformatf("dwait_state%0d", i), 32'(dut.state_q), 32'(DWAIT));
    end
    idle();
    checkOutput("dwait_exit_strobes", 32'(strobes), 32'h00);
    step();
    checkOutput("dwait_exit_state", 32'(dut.state_q), 32'(RUN));
    checkOutput("dwait_stall_cnt", 32'(hif.stall_cycles), 32'd3);
    checkOutput("dwait_err", 32'(hif.ctrl_err), 32'd0);

    // Watchdog: timeout of 4 enters ERR on the fifth busy edge
    doReset();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) step();
    checkOutput("to_state4", 32'(dut.state_q), 32'(DWAIT));
    checkOutput("to_err4", 32'(hif.ctrl_err), 32'd0);
    step();
    checkOutput("to_state5", 32'(dut.state_q), 32'(ERR));
    checkOutput("to_err5", 32'(hif.ctrl_err), 32'd1);
    idle();
    checkOutput("err_strobes", 32'(strobes), 32'b11001);
    step();
    checkOutput("err_sticky", 32'(hif.ctrl_err), 32'd1);
    checkOutput("err_state", 32'(dut.state_q), 32'(ERR));
    checkOutput("err_stall_cnt", 32'(hif.stall_cycles), 32'd6);
    rst = 1'b1;
    #1;
    checkOutput("err_rst_strobes", 32'(strobes), 32'h00);
    step();
    rst = 1'b0;
    idle();
    checkOutput("post_rst_state", 32'(dut.state_q), 32'(RUN));
    checkOutput("post_rst_err", 32'(hif.ctrl_err), 32'd0);
    checkOutput("post_rst_stall_cnt", 32'(hif.stall_cycles), 32'd0);
    checkOutput("post_rst_strobes", 32'(strobes), 32'h00);

    // Saturation: ten fetch-gap cycles on 3-bit counters
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput($sformatf("sat_stall%0d", i), 32'(hif.stall_cycles), (i > 7) ? 32'd7 : 32'(i));
      checkOutput($sformatf("sat_flush%0d", i), 32'(hif.flush_events), (i > 7) ? 32'd7 : 32'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Inspects ID/EX operands, EX branch resolution and memory readiness, then drives the stall and flush strobes for PC, IF_ID, ID_EX and EX_MEM.
- Sequences load-use bubbles, taken-branch flushes, and multi-cycle data-memory waits with a timeout watchdog.
- Keeps saturating performance counters for stall and flush events.

Parameters:
- CNT_W, 32, width of the stall_cycles and flush_events counters.
- DMEM_TIMEOUT, 255, maximum consecutive dmem_busy cycles before entering ERR.
- TO_W, 8, width of the wait counter; must hold DMEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock; state and counters update on posedge.
- rst  in  1  synchronous active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- imem_ready  in  1  instruction fetch data valid this cycle.
- dmem_busy  in  1  data memory not finished with the MEM-stage access.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold IF_ID; drives the IF_ID stall input.
- if_id_flush  out  1  load NOP (0x00000013) into IF_ID.
- id_ex_flush  out  1  load a bubble (all controls 0) into ID_EX.
- ex_mem_stall  out  1  hold ID_EX and EX_MEM.
- ctrl_err  out  1  sticky dmem timeout error.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1; saturating.
- flush_events  out  CNT_W  count of cycles with if_id_flush=1; saturating.

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Strobe timing: all strobes are combinational from registered state plus current inputs, so they settle before the negedge on which the pipeline registers sample.
- Reset: state=RUN, wait_cnt=0, ctrl_err=0, stall_cycles=0, flush_events=0.
  - While rst=1, every strobe output is 0.
- States: RUN, DWAIT, ERR.
- Load-use hazard:
  - load_use = ex_memread and ex_rd != 0 and ((id_use_rs1 and id_rs1 == ex_rd) or (id_use_rs2 and id_rs2 == ex_rd)).
- Priority in RUN and DWAIT, highest first; one case applies per cycle:
  1. dmem_busy=1:
     - pc_stall = if_id_stall = ex_mem_stall = 1; all flushes 0.
     - Next state DWAIT; wait_cnt increments.
     - When wait_cnt reaches DMEM_TIMEOUT while still busy: next state ERR.
  2. ex_branch_taken=1:
     - if_id_flush = id_ex_flush = 1; no stalls.
     - Overrides load_use, because the ID instruction is wrong-path.
  3. load_use=1:
     - pc_stall = if_id_stall = id_ex_flush = 1, for exactly one cycle.
     - The next cycle has ex_memread=0 (bubble), so detection clears on its own.
  4. imem_ready=0:
     - pc_stall = 1 and if_id_flush = 1, so a NOP enters ID while downstream keeps draining.
  5. Otherwise all strobes are 0.
- DWAIT exit:
  - When dmem_busy falls, return to RUN in that cycle; outputs follow the priority list for that cycle.
  - wait_cnt clears to 0.
- ERR:
  - pc_stall = if_id_stall = ex_mem_stall = 1; all flushes 0; ctrl_err = 1.
  - Leaves only on rst.
- Counters:
  - stall_cycles += 1 on each posedge with pc_stall=1.
  - flush_events += 1 on each posedge with if_id_flush=1.
  - Both hold at all-ones (saturate), never wrap.
- Simultaneous dmem_busy and ex_branch_taken: stall wins. The branch is reasserted by EX when the freeze ends, because EX is held.
- Reset mid-DWAIT or in ERR: the next cycle is RUN with all outputs 0 and counters cleared.

Decomposition:
- Shared package: state enum (RUN, DWAIT, ERR), NOP_INSTR = 32'h00000013, REG_ZERO = 5'd0.
- One natural sub-module, sat_counter (parameter W, inputs clk/rst/inc, output count), instantiated twice for the performance counters.
- Hazard compare and priority mux stay inline.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall = if_id_stall = id_ex_flush = 1 for exactly 1 cycle; stall_cycles=1.
- Load to x0 is not a hazard: ex_rd=0, id_rs1=0, id_use_rs1=1, ex_memread=1 -> all strobes 0.
- Branch overrides load-use: ex_branch_taken=1 together with the load-use condition -> if_id_flush = id_ex_flush = 1, pc_stall=0; flush_events=1.
- Memory wait: dmem_busy=1 for 3 cycles, then 0 -> pc_stall = if_id_stall = ex_mem_stall = 1 for 3 cycles; state DWAIT then RUN; stall_cycles=3; ctrl_err=0.
- Timeout: DMEM_TIMEOUT=4, dmem_busy held at 1 -> ERR entered on posedge 5 after assertion; ctrl_err=1 persists after dmem_busy drops; rst=1 for one cycle returns to RUN with counters at 0.
- Saturation: CNT_W=3, imem_ready=0 for 10 cycles -> stall_cycles = flush_events = 7, with no wrap to 0.
